// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction-fetch stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] c_fetch_reset_pc = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : Synchronous FIFO of fetched {pc, instr} entries; flush dominates.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic         head_valid,
  output fetch_entry_t head_entry,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != c_depth) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage carries no reset; the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst && !flush && w_push) r_mem[r_wr_ptr] <= push_entry;
  end

  assign head_valid = (r_count != '0);
  assign head_entry = head_valid ? r_mem[r_rd_ptr] : '0;
  assign count      = r_count;

endmodule : fetch_queue

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Fetch PC, single-outstanding imem request FSM, redirect/squash.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = c_fetch_reset_pc,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] c_depth = CW'(QUEUE_DEPTH);

  fetch_state_t  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic          r_run;
  logic [CW-1:0] w_count;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_head_valid;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_unused;

  // r_run keeps the request quiet while reset is held, using registers only.
  assign imem_req_valid = r_run && (r_state == IDLE) && (w_count < c_depth);
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_push         = (r_state == WAIT) && imem_resp_valid && !redirect_valid;
  assign w_pop          = w_head_valid && if_ready;
  assign w_push_entry   = '{pc: r_req_pc, instr: imem_resp_data};
  assign w_unused       = ^redirect_pc[1:0];

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head_valid (w_head_valid),
    .head_entry (w_head),
    .count      (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_run      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        case (r_state)
          IDLE:       r_state <= w_accept ? DROP : IDLE;
          WAIT, DROP: r_state <= imem_resp_valid ? IDLE : DROP;
          default:    r_state <= IDLE;
        endcase
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_req_pc   <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + 32'd4;
              r_state    <= WAIT;
            end
          end
          WAIT, DROP: if (imem_resp_valid) r_state <= IDLE;
          default:    r_state <= IDLE;
        endcase
      end
    end
  end

  assign if_valid = w_head_valid;
  assign if_pc    = w_head.pc;
  assign if_instr = w_head.instr;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Directed and randomized self-checking bench for fetch_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  // Memory model and architectural reference state
  bit          pend = 0;
  bit          pend_orphan = 0;
  logic [31:0] pend_addr = '0;
  int          pend_lat = 0;
  int          lat_fixed = 0;
  int          rdy_mode = 1;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_req = '0;
  int          n_pop = 0;
  int          n_acc = 0;
  logic [31:0] last_pop_pc = '0;
  logic [31:0] last_acc_addr = '0;
  bit          last_resp = 0;

  fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_ready        (if_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory, sample settled outputs, update the reference, advance.
  task automatic step();
    bit resp;
    bit acc;
    resp = pend && (pend_lat == 0);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(pend_addr) : $urandom;
    imem_req_ready  = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    #1;
    acc = imem_req_valid && imem_req_ready;
    last_resp = resp;
    if (!rst) begin
      chk("req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
      exp_pc = '0;
      exp_req = '0;
      pend_orphan = 1;
    end else begin
      chk("one_outstanding", {31'b0, imem_req_valid && pend && !pend_orphan}, 32'd0);
      if (acc) begin
        chk("req_addr", imem_req_addr, exp_req);
        last_acc_addr = imem_req_addr;
        exp_req += 32'd4;
        n_acc++;
      end
      if (if_valid && if_ready && !redirect_valid) begin
        chk("pop_pc", if_pc, exp_pc);
        chk("pop_instr", if_instr, mem_word(exp_pc));
        last_pop_pc = if_pc;
        exp_pc += 32'd4;
        n_pop++;
      end
      if (redirect_valid) begin
        exp_pc  = {redirect_pc[31:2], 2'b00};
        exp_req = {redirect_pc[31:2], 2'b00};
      end
    end
    if (resp) pend = 0;
    else if (pend && pend_lat > 0) pend_lat--;
    if (acc && rst) begin
      pend = 1;
      pend_orphan = 0;
      pend_addr = imem_req_addr;
      pend_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_pops(input int n);
    int start;
    start = n_pop;
    for (int i = 0; i < 200 && n_pop < start + n; i++) step();
    chk("pop_budget", 32'(n_pop - start), 32'(n));
  endtask

  task automatic run_until_acc(input int n);
    int start;
    start = n_acc;
    for (int i = 0; i < 200 && n_acc < start + n; i++) step();
    chk("acc_budget", 32'(n_acc - start), 32'(n));
  endtask

  initial begin
    int acc0;

    // 1: reset, always-ready 1-cycle memory, in-order stream from 0x0
    rst = 1'b0;
    @(posedge clk);
    #1;
    rdy_mode = 1;
    lat_fixed = 0;
    if_ready = 1'b1;
    repeat (3) step();
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    run_until_pops(3);
    chk("t1_third_pc", last_pop_pc, 32'h8);

    // 2: decode stalled -> two entries, no third request
    rst = 1'b0;
    if_ready = 1'b0;
    step();
    rst = 1'b1;
    acc0 = n_acc;
    repeat (10) step();
    chk("t2_accepts", 32'(n_acc - acc0), 32'd2);
    chk("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    chk("t2_head_valid", {31'b0, if_valid}, 32'd1);
    chk("t2_head_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    run_until_pops(3);
    chk("t2_third_pc", last_pop_pc, 32'h8);

    // 3: redirect while waiting on a slow response
    lat_fixed = 3;
    run_until_acc(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    lat_fixed = 0;
    run_until_acc(1);
    chk("t3_req_addr", last_acc_addr, 32'h100);
    run_until_pops(1);
    chk("t3_first_pc", last_pop_pc, 32'h100);

    // 4: redirect coincident with the response
    run_until_acc(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("t4_resp_same_cycle", {31'b0, last_resp}, 32'd1);
    chk("t4_queue_empty", {31'b0, if_valid}, 32'd0);
    chk("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h200);
    run_until_pops(1);
    chk("t4_first_pc", last_pop_pc, 32'h200);

    // 5: unaligned redirect target and PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    run_until_acc(1);
    chk("t5_aligned_addr", last_acc_addr, 32'h200);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    run_until_pops(3);
    chk("t5_wrap_pc", last_pop_pc, 32'h4);

    // 6: reset while a request is outstanding, response arrives afterwards
    lat_fixed = 5;
    run_until_acc(1);
    rst = 1'b0;
    rdy_mode = 0;
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < 20 && pend; i++) step();
    chk("t6_late_resp_seen", {31'b0, pend}, 32'd0);
    repeat (2) step();
    chk("t6_queue_empty", {31'b0, if_valid}, 32'd0);
    chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t6_req_addr", imem_req_addr, 32'h0);
    rdy_mode = 1;
    lat_fixed = 0;
    run_until_pops(2);
    chk("t6_restart_pc", last_pop_pc, 32'h4);

    // Random traffic: stalls, variable latency, random redirects
    rdy_mode = 2;
    lat_fixed = -1;
    for (int i = 0; i < 500; i++) begin
      if_ready = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    rdy_mode = 1;
    run_until_pops(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit

`default_nettype wire
